mhz_to_1hz: RTL and testbench



---
 rtl/mhz_to_1hz.sv | 55 +++++
 tb/tb_mhz_to_1hz.sv | 107 ++++++++++
 2 files changed

// File: rtl/mhz_to_1hz.sv
// Parameterised clock divider: registered 50 %-duty led_clk at CLK_HZ/(2*HALF).
// Define MHZ_TO_1HZ_TICK_EN to add the led_tick pulse output on led_clk rises.
module mhz_to_1hz #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned OUT_HZ = 1
) (
    input  logic S_clk,
    input  logic Reset,
    output logic led_clk
`ifdef MHZ_TO_1HZ_TICK_EN
    ,
    output logic led_tick
`endif
);

    // Guarded so an OUT_HZ of 0 reaches the parameter check instead of a divide-by-zero.
    localparam int unsigned HALF = (OUT_HZ == 0) ? 0 : CLK_HZ / (2 * OUT_HZ);
    localparam int unsigned CW   = (HALF <= 2) ? 1 : $clog2(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (OUT_HZ == 0 || HALF < 1) begin : g_param_check
        $error("mhz_to_1hz: CLK_HZ must be at least 2*OUT_HZ and OUT_HZ nonzero");
    end

    logic [CW-1:0] cnt;
    logic          wrap;

    always_comb begin
        wrap = (cnt == LAST);
    end

    always_ff @(posedge S_clk or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            led_clk <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            led_clk <= ~led_clk;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

`ifdef MHZ_TO_1HZ_TICK_EN
    // Fires on the same edge that raises led_clk, so the pulse lines up with the rise.
    always_ff @(posedge S_clk or posedge Reset) begin
        if (Reset) begin
            led_tick <= 1'b0;
        end else begin
            led_tick <= wrap & ~led_clk;
        end
    end
`endif

endmodule

// File: tb/tb_mhz_to_1hz.sv
// Directed bench for mhz_to_1hz: HALF=5, HALF=1 and truncated HALF=5 instances
// share one clock and reset; tick checks are enabled with MHZ_TO_1HZ_TICK_EN.
module tb_mhz_to_1hz;

    logic S_clk = 1'b0;
    logic Reset = 1'b1;
    logic clk5, clk1, clk11;
`ifdef MHZ_TO_1HZ_TICK_EN
    logic tick5, tick1, tick11;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Bit (k-1) is the expected output after the k-th edge following release.
    logic [19:0] exp5    = 20'b0_11111_00000_11111_0000;
    logic [19:0] exp1    = 20'b01010101010101010101;
    logic [19:0] exptick = 20'b0_00001_00000_00001_0000;

    always #5 S_clk = ~S_clk;

    mhz_to_1hz #(.CLK_HZ(10), .OUT_HZ(1)) u_h5 (
        .S_clk(S_clk), .Reset(Reset), .led_clk(clk5)
`ifdef MHZ_TO_1HZ_TICK_EN
        , .led_tick(tick5)
`endif
    );

    mhz_to_1hz #(.CLK_HZ(2), .OUT_HZ(1)) u_h1 (
        .S_clk(S_clk), .Reset(Reset), .led_clk(clk1)
`ifdef MHZ_TO_1HZ_TICK_EN
        , .led_tick(tick1)
`endif
    );

    mhz_to_1hz #(.CLK_HZ(11), .OUT_HZ(1)) u_h11 (
        .S_clk(S_clk), .Reset(Reset), .led_clk(clk11)
`ifdef MHZ_TO_1HZ_TICK_EN
        , .led_tick(tick11)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_edge(input int k);
        check($sformatf("h5_e%0d", k),  32'(clk5),  32'(exp5[k-1]));
        check($sformatf("h1_e%0d", k),  32'(clk1),  32'(exp1[k-1]));
        check($sformatf("h11_e%0d", k), 32'(clk11), 32'(exp5[k-1]));
`ifdef MHZ_TO_1HZ_TICK_EN
        check($sformatf("tick5_e%0d", k),  32'(tick5),  32'(exptick[k-1]));
        check($sformatf("tick11_e%0d", k), 32'(tick11), 32'(exptick[k-1]));
        check($sformatf("tick1_e%0d", k),  32'(tick1),  32'(exp1[k-1]));
`endif
    endtask

    initial begin
        repeat (3) @(posedge S_clk);
        #1;
        check("rst_h5",  32'(clk5),  32'd0);
        check("rst_h1",  32'(clk1),  32'd0);
        check("rst_h11", 32'(clk11), 32'd0);
        check("rst_cnt", 32'(u_h5.cnt), 32'd0);
`ifdef MHZ_TO_1HZ_TICK_EN
        check("rst_tick", 32'(tick5), 32'd0);
`endif
        @(negedge S_clk);
        Reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge S_clk);
            #1;
            check_edge(k);
        end

        // Restart, then hit the HALF=5 divider with an async reset mid-high-phase.
        @(negedge S_clk);
        Reset = 1'b1;
        @(negedge S_clk);
        Reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge S_clk);
            #1;
            check_edge(k);
        end
        @(negedge S_clk);
        Reset = 1'b1;
        #1;
        check("async_clk", 32'(clk5), 32'd0);
        check("async_cnt", 32'(u_h5.cnt), 32'd0);
        #1;
        Reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge S_clk);
            #1;
            check_edge(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
